// File: rtl/casex_pkg.sv
// Shared constants, FSM state type and casex priority function
// for the request-side priority encoder.
package casex_pkg;

  localparam int N_REQ  = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  // Returns {any, code}; highest set index wins.
  function automatic logic [CODE_W:0] prio_enc(
    input logic [N_REQ-1:0] vec
  );
    logic [CODE_W:0] r;
    r = '0;
    casex (vec)
      8'b1???????: r = {1'b1, 3'd7};
      8'b01??????: r = {1'b1, 3'd6};
      8'b001?????: r = {1'b1, 3'd5};
      8'b0001????: r = {1'b1, 3'd4};
      8'b00001???: r = {1'b1, 3'd3};
      8'b000001??: r = {1'b1, 3'd2};
      8'b0000001?: r = {1'b1, 3'd1};
      8'b00000001: r = {1'b1, 3'd0};
      default:     r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/casex_prio_enc8.sv
// Combinational 8-to-3 priority encoder built on the
// shared casex table.
module casex_prio_enc8
  import casex_pkg::*;
(
  input  logic [N_REQ-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              any
);

  logic [CODE_W:0] r;

  always_comb begin
    r    = prio_enc(vec);
    code = r[CODE_W-1:0];
    any  = r[CODE_W];
  end

endmodule

// File: rtl/casex_prio_encoder.sv
// Sticky request collector with priority grant presented
// on a valid/ready handshake.
module casex_prio_encoder
  import casex_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic [N_REQ-1:0]  req,
  output logic [CODE_W-1:0] code,
  output logic              code_valid,
  input  logic              code_ready,
  output logic [N_REQ-1:0]  pending,
  output logic              collision
);

  state_t            state_q;
  state_t            state_d;
  logic [CODE_W-1:0] code_q;
  logic [CODE_W-1:0] code_d;
  logic [N_REQ-1:0]  pend_q;
  logic [N_REQ-1:0]  served;
  logic [N_REQ-1:0]  sel;
  logic [CODE_W-1:0] enc;
  logic              any;
  logic              accept;
  logic              coll_q;

  assign code_valid = (state_q == HOLD);
  assign accept     = code_valid & code_ready;
  assign served     = accept ? (N_REQ'(1) << code_q) : '0;
  assign sel        = pend_q & ~served;

  casex_prio_enc8 u_enc (
    .vec  (sel),
    .code (enc),
    .any  (any)
  );

  // Code is frozen in HOLD until the downstream accepts it.
  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    unique case (state_q)
      IDLE: begin
        if (any) begin
          code_d  = enc;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (accept) begin
          if (any) code_d = enc;
          else     state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      code_q  <= '0;
      pend_q  <= '0;
      coll_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pend_q  <= (pend_q & ~served) | req;
      coll_q  <= |(req & pend_q & ~served);
    end
  end

  assign code      = code_q;
  assign pending   = pend_q;
  assign collision = coll_q;

endmodule

// File: tb/tb_casex_prio_encoder.sv
// Scoreboard bench: expected grant codes are queued with the
// stimulus and popped by a monitor on every handshake.
module tb_casex_prio_encoder;

  logic       clk;
  logic       rstn;
  logic [7:0] req;
  logic [2:0] code;
  logic       code_valid;
  logic       code_ready;
  logic [7:0] pending;
  logic       collision;

  int n_chk;
  int n_fail;
  logic [2:0] sb[$];

  casex_prio_encoder dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .code       (code),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .pending    (pending),
    .collision  (collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: handshake seen mid-cycle is accepted at next rise.
  always @(negedge clk) begin
    if (rstn && code_valid && code_ready) begin
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got code %0d, none expected",
                 code);
      end else begin
        logic [2:0] e;
        e = sb.pop_front();
        if (code !== e) begin
          n_fail++;
          $display("FAIL sb_code: got %0d, expected %0d", code, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    req = '0;
    code_ready = 1'b0;
    #1;
    n_chk++;
    if ({code_valid, pending, collision, code} !== 15'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%b pend=%h coll=%b code=%0d",
               code_valid, pending, collision, code);
    end
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_chk++;
      if (code_valid !== 1'b0 || pending !== 8'h00 ||
          collision !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_%0d: valid=%b pend=%h coll=%b",
                 i, code_valid, pending, collision);
      end
    end
  endtask

  task automatic test_single();
    req = 8'h04;
    code_ready = 1'b1;
    sb.push_back(3'd2);
    tick();
    req = '0;
    n_chk++;
    if (pending !== 8'h04 || code_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_capture: pend=%h valid=%b, want 04/0",
               pending, code_valid);
    end
    tick();
    n_chk++;
    if (code_valid !== 1'b1 || code !== 3'd2) begin
      n_fail++;
      $display("FAIL single_grant: valid=%b code=%0d, want 1/2",
               code_valid, code);
    end
    tick();
    n_chk++;
    if (code_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL single_retire: valid=%b pend=%h, want 0/00",
               code_valid, pending);
    end
  endtask

  task automatic test_all_pending();
    req = 8'hFF;
    code_ready = 1'b1;
    for (int i = 7; i >= 0; i--) sb.push_back(3'(i));
    tick();
    req = '0;
    n_chk++;
    if (pending !== 8'hFF) begin
      n_fail++;
      $display("FAIL all_capture: pend=%h, want ff", pending);
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_chk++;
      if (code_valid !== 1'b1 || code !== 3'(7 - i)) begin
        n_fail++;
        $display("FAIL all_seq_%0d: valid=%b code=%0d, want 1/%0d",
                 i, code_valid, code, 7 - i);
      end
    end
    tick();
    n_chk++;
    if (code_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL all_done: valid=%b pend=%h, want 0/00",
               code_valid, pending);
    end
  endtask

  task automatic test_backpressure();
    code_ready = 1'b0;
    req = 8'h01;
    sb.push_back(3'd0);
    sb.push_back(3'd7);
    tick();
    req = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      req = (i == 1) ? 8'h80 : 8'h00;
      tick();
      n_chk++;
      if (code_valid !== 1'b1 || code !== 3'd0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: valid=%b code=%0d, want 1/0",
                 i, code_valid, code);
      end
    end
    req = '0;
    n_chk++;
    if (pending !== 8'h81) begin
      n_fail++;
      $display("FAIL bp_pending: pend=%h, want 81", pending);
    end
    code_ready = 1'b1;
    tick();
    n_chk++;
    if (code_valid !== 1'b1 || code !== 3'd7) begin
      n_fail++;
      $display("FAIL bp_next: valid=%b code=%0d, want 1/7",
               code_valid, code);
    end
    tick();
    n_chk++;
    if (code_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL bp_idle: valid=%b pend=%h, want 0/00",
               code_valid, pending);
    end
  endtask

  task automatic test_collision();
    code_ready = 1'b0;
    req = 8'h08;
    sb.push_back(3'd3);
    tick();
    req = '0;
    tick();
    n_chk++;
    if (code_valid !== 1'b1 || code !== 3'd3 ||
        collision !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_pre: valid=%b code=%0d coll=%b",
               code_valid, code, collision);
    end
    req = 8'h08;
    tick();
    req = '0;
    n_chk++;
    if (collision !== 1'b1 || pending !== 8'h08) begin
      n_fail++;
      $display("FAIL coll_pulse: coll=%b pend=%h, want 1/08",
               collision, pending);
    end
    tick();
    n_chk++;
    if (collision !== 1'b0 || pending !== 8'h08) begin
      n_fail++;
      $display("FAIL coll_clear: coll=%b pend=%h, want 0/08",
               collision, pending);
    end
    code_ready = 1'b1;
    tick();
    n_chk++;
    if (code_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL coll_retire: valid=%b pend=%h, want 0/00",
               code_valid, pending);
    end
  endtask

  task automatic test_reset_mid();
    code_ready = 1'b0;
    req = 8'h30;
    tick();
    req = '0;
    tick();
    n_chk++;
    if (code_valid !== 1'b1 || code !== 3'd5 ||
        pending !== 8'h30) begin
      n_fail++;
      $display("FAIL rm_pre: valid=%b code=%0d pend=%h",
               code_valid, code, pending);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_chk++;
    if (code_valid !== 1'b0 || pending !== 8'h00) begin
      n_fail++;
      $display("FAIL rm_async: valid=%b pend=%h, want 0/00",
               code_valid, pending);
    end
    sb.delete();
    tick();
    rstn = 1'b1;
    code_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if (code_valid !== 1'b0 || pending !== 8'h00) begin
        n_fail++;
        $display("FAIL rm_quiet_%0d: valid=%b pend=%h",
                 i, code_valid, pending);
      end
    end
    req = 8'h02;
    sb.push_back(3'd1);
    tick();
    req = '0;
    tick();
    n_chk++;
    if (code_valid !== 1'b1 || code !== 3'd1) begin
      n_fail++;
      $display("FAIL rm_new: valid=%b code=%0d, want 1/1",
               code_valid, code);
    end
    tick();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_single();
    test_all_pending();
    test_backpressure();
    test_collision();
    test_reset_mid();
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d grants left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/casex_prio_encoder.md
Name: casex_prio_encoder

Overview:
- Request-side counterpart to the team's casex state decoders.
- Collects sticky request lines and priority-encodes the highest pending request into a 3-bit code using casex-style wildcard priority.
- Presents the code on a valid/ready handshake to a downstream decoder.
- Retires each request once the downstream has accepted its code.

Parameters:
- N_REQ, 8, number of request lines; fixed at 8 for this revision.
- CODE_W, 3, code width; must equal clog2(N_REQ).

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- req  input  N_REQ  request pulses or levels, sampled every rising edge
- code  output  CODE_W  encoded index of the granted request
- code_valid  output  1  code is presented
- code_ready  input  1  downstream accepts code this cycle
- pending  output  N_REQ  registered sticky pending vector
- collision  output  1  one-cycle pulse: a req bit arrived while that bit was already pending

Behaviour:
- Reset (rstn low, asynchronous):
  - pending=0, code=0, code_valid=0, collision=0.
  - FSM forced to IDLE.
  - Any transfer in flight is discarded.
- Accept condition: accept = code_valid & code_ready.
- Pending update, each edge: pending <= (pending & ~served) | req.
  - served is the one-hot of code when accept is high, else 0.
  - If req sets the same bit that is being served, the bit stays set; the new request wins.
- collision <= |(req & pending & ~served), registered, one cycle.
- Priority, highest index wins, casex order:
  - 1??????? -> 7
  - 01?????? -> 6
  - …
  - 00000001 -> 0
  - 00000000 -> no grant
- Selection source: sel = pending & ~served.
  - Same-cycle req is not used.
  - New requests become visible to selection one edge after they are sampled.
- FSM states: IDLE, HOLD.
  - IDLE:
    - code_valid=0.
    - If sel != 0: load code=prio(sel), code_valid<=1, go to HOLD.
  - HOLD:
    - code_valid=1.
    - code is frozen while code_ready=0, even if a higher-priority request arrives.
    - On accept with sel != 0: load code=prio(sel), stay in HOLD, code_valid stays 1 (back-to-back, one grant per cycle).
    - On accept with sel == 0: go to IDLE, code_valid<=0, code holds its last value.
- Latency:
  - req sampled at edge k -> pending at edge k.
  - From IDLE, code_valid at edge k+1.
  - Minimum req-to-valid latency is 1 cycle after capture.
- Boundary conditions:
  - All 8 bits pending: grants come out 7,6,…,0 on consecutive cycles with code_ready held high.
  - code_ready high while code_valid=0: ignored; nothing is served.
  - Reset asserted mid-HOLD: code_valid drops immediately (asynchronously).
  - No X propagation: unused casex default maps to code 0 with no grant.

Decomposition:
- Shared package casex_pkg:
  - CODE_W and N_REQ constants.
  - FSM state typedef (IDLE, HOLD).
  - Function prio_enc(vec) implementing the casex priority table.
- One combinational sub-module is natural: casex_prio_enc8.
  - Inputs: 8-bit vector.
  - Outputs: 3-bit code and any-bit flag.
  - Reusable by the decoder-side tests.
- Top level holds the pending register, the FSM and the collision logic.

Test Plan:
1. Reset, then req=8'h00 for 10 cycles -> code_valid=0, pending=8'h00 throughout, collision=0.
2. Single pulse req=8'h04 at one edge, code_ready=1 -> pending=8'h04, next edge code=3'd2 with code_valid=1, then pending=8'h00 and code_valid=0 one cycle later.
3. req=8'hFF pulse, code_ready=1 continuously -> codes 7,6,5,4,3,2,1,0 on 8 consecutive cycles, then code_valid=0 and pending=0.
4. Backpressure:
   - Stimulus: req=8'h01 granted (code=0), code_ready=0 for 5 cycles, req=8'h80 arrives meanwhile.
   - Response: code stays 0 until accept, then next code=7, then idle.
5. Collision: pending bit 3 set and held unaccepted, req=8'h08 again -> collision pulses 1 for exactly one cycle, pending unchanged at 8'h08.
6. Reset mid-operation: pending=8'h30 with code_valid=1, drop rstn between clock edges -> code_valid=0 and pending=0 immediately; after release, no grants until a new req.
